// File: rtl/frequency_divider_by3_pkg.sv
// Shared helpers for the odd/even clock divider.
// Derives the high-phase length from the division ratio.
package frequency_divider_by3_pkg;

  // Number of posedge-timed high cycles per output period.
  // For odd ratios the extra half cycle comes from the
  // negedge copy of the phase.
  function automatic int half_of(input int div);
    if (div % 2 == 1)
      return (div - 1) / 2;
    return div / 2;
  endfunction

  function automatic bit is_odd(input int div);
    return (div % 2) == 1;
  endfunction

endpackage

// File: rtl/frequency_divider_by3_mod_n_counter.sv
// Modulus-DIV up counter with synchronous active-high reset.
// Ports: clk, rst in; cnt_next out (value loaded at next posedge).
module mod_n_counter #(
  parameter int DIV = 3,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt_next
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Wrap straight from DIV-1 to 0; no idle state.
  always_comb begin
    cnt_next = cnt_q + 1'b1;
    if (cnt_q == LAST)
      cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_next;
  end

endmodule

// File: rtl/frequency_divider_by3.sv
// Divides clk by DIV with a 50% duty output clock.
// Ports: clk, rst (sync, active-high) in; out_clk out.
module frequency_divider_by3
  import frequency_divider_by3_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic out_clk
);

  localparam int CW = $clog2(DIV);
  localparam bit ODD = is_odd(DIV);
  localparam logic [CW-1:0] HALF =
    CW'(half_of(DIV));

  logic [CW-1:0] cnt_next;
  logic          p_q;
  logic          n_q;

  mod_n_counter #(
    .DIV (DIV),
    .CW  (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .cnt_next (cnt_next)
  );

  // Posedge phase: high for the first HALF counts.
  always_ff @(posedge clk) begin
    if (rst)
      p_q <= 1'b0;
    else
      p_q <= (cnt_next < HALF);
  end

  // Half-cycle-late copy stretches the high phase
  // by T/2 for odd ratios; unused for even ratios.
  always_ff @(negedge clk) begin
    if (rst)
      n_q <= 1'b0;
    else
      n_q <= ODD ? p_q : 1'b0;
  end

  // Both inputs are flops; the OR is glitch-free since
  // p_q falls only while n_q holds the output high.
  assign out_clk = p_q | n_q;

endmodule

// File: tb/tb_frequency_divider_by3.sv
// Self-checking bench for frequency_divider_by3.
// Covers DIV=3 (table + random) and DIV=4/5 timing.
`timescale 1ns/1ps
module tb_frequency_divider_by3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] oc;
  logic       meas = 1'b0;

  int checks = 0;
  int failures = 0;

  always #2.5 clk = ~clk;

  frequency_divider_by3 #(.DIV(3)) dut3 (
    .clk(clk), .rst(rst), .out_clk(oc[0]));
  frequency_divider_by3 #(.DIV(4)) dut4 (
    .clk(clk), .rst(rst), .out_clk(oc[1]));
  frequency_divider_by3 #(.DIV(5)) dut5 (
    .clk(clk), .rst(rst), .out_clk(oc[2]));

  function automatic int dv(input int g);
    return g + 3;
  endfunction

  task automatic chk(input string nm,
                     input logic got,
                     input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b",
               nm, got, exp);
    end
  endtask

  task automatic chk_t(input string nm,
                       input realtime got,
                       input realtime exp);
    checks++;
    if (got < exp - 0.01 || got > exp + 0.01) begin
      failures++;
      $display("FAIL %s got=%0.3f exp=%0.3f",
               nm, got, exp);
    end
  endtask

  // Reference: k = posedges with rst=0 since reset.
  // Output goes high at k%DIV==0 for floor(DIV/2)
  // cycles, stretched by half a cycle for odd DIV.
  int k [3];
  bit ph [3];
  bit tail [3];
  logic ep0, en0;

  task automatic model_pos(input logic r);
    for (int g = 0; g < 3; g++) begin
      if (r) k[g] = 0;
      else k[g]++;
      ph[g] = (k[g] > 0) &&
              ((k[g] % dv(g)) < (dv(g) / 2));
    end
  endtask

  task automatic model_neg(input logic r);
    for (int g = 0; g < 3; g++)
      tail[g] = (dv(g) % 2 == 1) && !r && ph[g];
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    model_pos(r);
    for (int g = 0; g < 3; g++)
      chk($sformatf("pos_div%0d", dv(g)),
          oc[g], ph[g] | tail[g]);
    chk("div3_cnt", logic'(
        dut3.u_cnt.cnt_q == 2'(k[0] % 3)), 1'b1);
    ep0 = oc[0];
    @(negedge clk);
    #1;
    model_neg(r);
    for (int g = 0; g < 3; g++)
      chk($sformatf("neg_div%0d", dv(g)),
          oc[g], ph[g] | tail[g]);
    chk("div4_n_zero", dut4.n_q, 1'b0);
    en0 = oc[0];
  endtask

  typedef struct {
    logic r;
    logic ep;
    logic en;
  } vec_t;

  vec_t tbl [15];

  for (genvar g = 0; g < 3; g++) begin : g_meas
    realtime lr = 0.0;
    int rises = 0;
    always @(posedge oc[g]) if (meas) begin
      if (rises > 0)
        chk_t($sformatf("period_div%0d", dv(g)),
              $realtime - lr, dv(g) * 5.0);
      lr = $realtime;
      rises++;
    end
    always @(negedge oc[g]) if (meas && rises > 0)
      chk_t($sformatf("high_div%0d", dv(g)),
            $realtime - lr, dv(g) * 2.5);
  end

  initial begin
    // Hold, release, mid-run reset while high,
    // and restart, all for DIV=3.
    tbl[0]  = '{1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r);
      chk($sformatf("tbl%0d_pos", i),
          ep0, tbl[i].ep);
      chk($sformatf("tbl%0d_neg", i),
          en0, tbl[i].en);
    end

    for (int i = 0; i < 300; i++)
      step(logic'($urandom_range(0, 19) == 0));

    step(1'b1);
    step(1'b0);
    step(1'b0);
    meas = 1'b1;
    for (int i = 0; i < 110; i++)
      step(1'b0);
    meas = 1'b0;

    checks++;
    if (g_meas[0].rises < 20) begin
      failures++;
      $display("FAIL rises_div3 got=%0d exp>=20",
               g_meas[0].rises);
    end
    checks++;
    if (g_meas[1].rises < 20) begin
      failures++;
      $display("FAIL rises_div4 got=%0d exp>=20",
               g_meas[1].rises);
    end
    checks++;
    if (g_meas[2].rises < 20) begin
      failures++;
      $display("FAIL rises_div5 got=%0d exp>=20",
               g_meas[2].rises);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
